// File: rtl/push_conditioner.sv
// Push-button conditioner: debounces an already-synchronous button level and
// emits one scored strobe per accepted press, with post-press lockout and a saturating count.
module push_conditioner #(
  parameter int DEB_CYCLES     = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             synchronous_push,
  input  logic             enable,
  input  logic             count_clr,
  output logic             press_pulse,
  output logic             pressed_level,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {RELEASED, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    deb_cnt, deb_nxt;
  logic [LW-1:0]    lock_cnt, lock_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             accept, issue, level_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    accept    = 1'b0;
    case (state)
      RELEASED: begin
        if (synchronous_push) begin
          state_nxt = DEB_PRESS;
          deb_nxt   = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!synchronous_push) begin
          state_nxt = RELEASED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          deb_nxt   = '0;
          accept    = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!synchronous_push) begin
          state_nxt = DEB_RELEASE;
          deb_nxt   = DW'(1);
        end
      end
      DEB_RELEASE: begin
        if (synchronous_push) begin
          state_nxt = HELD;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = RELEASED;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        deb_nxt   = '0;
      end
    endcase

    // A press is scored only when the game runs and no lockout is pending.
    issue     = accept && enable && (lock_cnt == '0);
    lock_nxt  = issue ? LOCK_LOAD : ((lock_cnt != '0) ? lock_cnt - 1'b1 : lock_cnt);
    count_nxt = count_clr ? '0 : (issue ? sat_inc(press_count) : press_count);
    level_nxt = (state_nxt == HELD) || (state_nxt == DEB_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      lock_cnt      <= '0;
      press_pulse   <= 1'b0;
      pressed_level <= 1'b0;
      busy          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      lock_cnt      <= lock_nxt;
      press_pulse   <= issue;
      pressed_level <= level_nxt;
      busy          <= (lock_nxt != '0);
      press_count   <= count_nxt;
    end
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner: bounce, lockout, enable, hold, reset
// and saturation scenarios with hand-computed expectations.
module tb_push_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0, enable = 1'b1, count_clr = 1'b0;
  logic       press_pulse, pressed_level, busy;
  logic [7:0] press_count;
  logic       push2 = 1'b0, clr2 = 1'b0;
  logic       pulse2, level2, busy2;
  logic [1:0] count2;

  int checks = 0, failures = 0;
  int pulses = 0, pulses2 = 0;

  always #5 clk = ~clk;

  push_conditioner u_dut (
    .clk(clk), .rst(rst), .synchronous_push(push), .enable(enable),
    .count_clr(count_clr), .press_pulse(press_pulse),
    .pressed_level(pressed_level), .busy(busy), .press_count(press_count)
  );

  push_conditioner #(.DEB_CYCLES(4), .LOCKOUT_CYCLES(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .synchronous_push(push2), .enable(1'b1),
    .count_clr(clr2), .press_pulse(pulse2),
    .pressed_level(level2), .busy(busy2), .press_count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then observed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    pulses  += int'(press_pulse);
    pulses2 += int'(pulse2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lvl_seen, lvl_drop;

    // Reset state
    rst = 1'b0; push = 1'b1; count_clr = 1'b1;
    ticks(2);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_level", pressed_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", press_count, 0);
    push = 1'b0; count_clr = 1'b0; rst = 1'b1;
    ticks(2);

    // Bounce: 3 high, 1 low, 4 high
    pulses = 0;
    push = 1'b1; ticks(3);
    push = 1'b0; tick();
    push = 1'b1; ticks(3);
    chk("bounce_no_early", pulses, 0);
    chk("bounce_level_low", pressed_level, 0);
    tick();
    chk("bounce_pulse", press_pulse, 1);
    chk("bounce_level", pressed_level, 1);
    chk("bounce_busy", busy, 1);
    chk("bounce_count", press_count, 1);

    // Lockout: debounced release then re-press inside the busy window
    push = 1'b0; ticks(4);
    chk("lock_released", pressed_level, 0);
    chk("lock_busy_mid", busy, 1);
    push = 1'b1; ticks(3);
    chk("lock_busy_last", busy, 1);
    tick();
    chk("lock_busy_fall", busy, 0);
    chk("lock_level", pressed_level, 1);
    chk("lock_pulses", pulses, 1);
    chk("lock_count", press_count, 1);
    push = 1'b0; ticks(4);
    chk("lock_rel2", pressed_level, 0);

    // Clear, then enable=0 with a clean 10-cycle press
    count_clr = 1'b1; tick(); count_clr = 1'b0;
    chk("clr_count", press_count, 0);
    enable = 1'b0; pulses = 0; lvl_seen = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      lvl_seen |= pressed_level;
    end
    push = 1'b0; ticks(4);
    chk("en_level_seen", lvl_seen, 1);
    chk("en_level_end", pressed_level, 0);
    chk("en_pulses", pulses, 0);
    chk("en_count", press_count, 0);
    chk("en_busy", busy, 0);
    enable = 1'b1;

    // Hold for 100 cycles: one pulse, level stays high after acceptance
    pulses = 0; lvl_drop = 1'b0;
    push = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 4) chk("hold_pulse_at4", press_pulse, 1);
      if (i >= 4 && !pressed_level) lvl_drop = 1'b1;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_no_drop", lvl_drop, 0);
    chk("hold_count", press_count, 1);
    push = 1'b0; ticks(12);

    // Reset while HELD and busy, button held through reset release
    push = 1'b1; ticks(4);
    chk("rtest_pulse", press_pulse, 1);
    tick();
    chk("rtest_busy", busy, 1);
    rst = 1'b0; ticks(2);
    chk("rtest_pulse0", press_pulse, 0);
    chk("rtest_level0", pressed_level, 0);
    chk("rtest_busy0", busy, 0);
    chk("rtest_count0", press_count, 0);
    rst = 1'b1; pulses = 0;
    ticks(3);
    chk("rtest_no_early", pulses, 0);
    chk("rtest_level_early", pressed_level, 0);
    tick();
    chk("rtest_pulse_late", press_pulse, 1);
    chk("rtest_count1", press_count, 1);
    push = 1'b0; ticks(12);

    // Saturation on the CNT_W=2, no-lockout instance
    pulses2 = 0;
    for (int p = 1; p <= 4; p++) begin
      push2 = 1'b1; ticks(4);
      push2 = 1'b0; ticks(4);
      if (p == 2) chk("sat_count2", count2, 2);
      if (p == 3) chk("sat_count3", count2, 3);
    end
    chk("sat_count4", count2, 3);
    chk("sat_pulses4", pulses2, 4);
    push2 = 1'b1; ticks(3);
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    chk("sat_pulse5", pulse2, 1);
    chk("sat_clr_wins", count2, 0);
    chk("sat_busy", busy2, 0);
    push2 = 1'b0; ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
